// File: rtl/mult_ctrl_pkg.sv
// mult_ctrl_pkg: shared types, constants and helpers for the execute-stage
// multiplier front-end (operand path and result path both use sext32).
package mult_ctrl_pkg;

    typedef logic [63:0] u64;
    typedef logic [4:0]  u5;
    typedef logic        u1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mult_state_t;

    localparam int MUL_LAT_DEFAULT = 1;

    function automatic u64 sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/mult_ctrl.sv
// mult_ctrl: accepts one MUL/MULW request at a time, holds its operands
// stable at the multiplier for the full latency, captures and formats the
// product, and hands it to writeback. A flush kills the in-flight op.
module mult_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_word,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  logic [4:0]  in_rd,
    output logic [63:0] mul_a,
    output logic [63:0] mul_b,
    output logic        mul_signed,
    input  logic [63:0] mul_c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [4:0]  out_rd
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT);

    mult_state_t      state;
    logic [CNT_W-1:0] cnt;
    u64               op_a;
    u64               op_b;
    u1                op_word;
    u5                rd_q;
    u64               res;
    u1                out_valid_q;

    u1                accept;
    u64               nxt_a;
    u64               nxt_b;

    // A new request may enter when idle, or when the held result is being
    // consumed this same cycle; never during reset or a flush.
    always_comb begin
        in_ready = 1'b0;
        if (!reset && !flush) begin
            case (state)
                IDLE:    in_ready = 1'b1;
                DONE:    in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    // MULW operates on the sign-extended low words; MUL passes operands through.
    always_comb begin
        accept = in_valid && in_ready;
        nxt_a  = in_word ? sext32(in_a[31:0]) : in_a;
        nxt_b  = in_word ? sext32(in_b[31:0]) : in_b;
    end

    // Control FSM with latency counter, operand registers and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_word     <= 1'b0;
            rd_q        <= '0;
            res         <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a    <= nxt_a;
                        op_b    <= nxt_b;
                        op_word <= in_word;
                        rd_q    <= in_rd;
                        cnt     <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == CNT_LAST) begin
                        res         <= op_word ? sext32(mul_c[31:0]) : mul_c;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (accept) begin
                            op_a    <= nxt_a;
                            op_b    <= nxt_b;
                            op_word <= in_word;
                            rd_q    <= in_rd;
                            cnt     <= '0;
                            state   <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mul_a      = op_a;
    assign mul_b      = op_b;
    assign mul_signed = op_word;
    assign out_valid  = out_valid_q;
    assign out_data   = res;
    assign out_rd     = rd_q;

endmodule

// File: doc/mult_ctrl.md
# mult_ctrl

Sequencing front-end for the execute-stage 64-bit multiplier. It accepts RV64 MUL/MULW requests from the execute issue logic over a valid/ready handshake and registers the operands. It holds those operands stable at the multiplier for its full latency, because the multiplier's output sign-correction reads the live operands. It then captures the product, formats MULW results, and presents them to writeback over a valid/ready handshake. One operation is in flight at a time, and a pipeline flush kills it.

## Interface
- MUL_LAT, default 1: clock edges from operands first driven on mul_a/mul_b to mul_c valid; legal range 1–7.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  kill the in-flight op; synchronous
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_word  in  1  1 = MULW, 0 = MUL
- in_a  in  64  rs1 value
- in_b  in  64  rs2 value
- in_rd  in  5  destination tag, returned unchanged
- mul_a  out  64  operand A to multiplier
- mul_b  out  64  operand B to multiplier
- mul_signed  out  1  multiplier signed mode
- mul_c  in  64  multiplier product (low 64 bits)
- out_valid  out  1  result valid
- out_ready  in  1  writeback accepts when out_valid && out_ready
- out_data  out  64  formatted result
- out_rd  out  5  tag of result

## Operation
- States:
  - IDLE: in_ready = !flush.
  - BUSY: counter cnt running.
  - DONE: result held.
- IDLE → BUSY on accept:
  - Register the operands.
  - MUL: op_a = in_a, op_b = in_b, signed = 0.
  - MULW: op_a = sext(in_a[31:0]), op_b = sext(in_b[31:0]), signed = 1.
  - cnt ← 0.
- BUSY:
  - mul_a/mul_b/mul_signed are driven from the operand registers and stay constant throughout.
  - cnt increments each cycle.
  - When cnt == MUL_LAT, capture mul_c into the result register and go to DONE.
  - cnt width = $clog2(MUL_LAT+1).
- Result formatting at capture:
  - MUL: out_data = mul_c.
  - MULW: out_data = sext(mul_c[31:0]).
- DONE:
  - out_valid = 1; out_data and out_rd are held until out_ready.
  - On out_ready with no new accept, go to IDLE.
  - in_ready = out_ready && !flush. This allows back-to-back issue: a new accept in the same cycle goes directly to BUSY.
- Operand registers keep their value in IDLE/DONE. mul_* outputs are don't-care outside BUSY, but must not glitch during BUSY.
- flush:
  - Takes priority over everything; next state = IDLE.
  - No result is produced for the killed op.
  - A request presented in the flush cycle is not accepted (in_ready = 0).
- Reset values:
  - state IDLE; cnt 0; operand and result registers 0.
  - out_valid 0, out_data 0, out_rd 0, mul_a 0, mul_b 0, mul_signed 0.
  - in_ready is 0 during reset and 1 in the first cycle after it (absent flush).

## Timing
- Accept in cycle T; mul_a/mul_b are valid from T+1.
- mul_c is captured at the edge ending cycle T+1+MUL_LAT; out_valid rises in T+2+MUL_LAT. With the default, that is T+3.
- Throughput is one op per MUL_LAT+2 cycles with out_ready held high.
- out_valid stays high and out_data/out_rd stay stable until the handshake completes. out_valid never drops without a handshake except on flush or reset.
- flush in cycle F: out_valid = 0 from F+1 and in_ready = 1 from F+1.
- reset mid-BUSY: same as flush, plus all registers are zeroed.
- flush and out_ready both high in DONE: the handshake counts; the result is consumed and not lost.

## Structure
- Shared package entries:
  - mult_state_t enum {IDLE, BUSY, DONE}
  - MUL_LAT_DEFAULT constant
  - sext32 function (used by the operand path and the result path)
- Reuse the existing u64/u5/u1 typedefs from the shared interface header.
- No sub-module: a single FSM plus counter plus registers.
- The multiplier is instantiated by the execute top and connected via the mul_* ports.
- The bench uses a behavioural multiplier model: registered low 64-bit product with latency MUL_LAT, output corrupted to X whenever the operands change mid-latency.

## Test plan
- MUL a = 3, b = 0xFFFF_FFFF_FFFF_FFFB (−5), out_ready = 1 → out_data = 0xFFFF_FFFF_FFFF_FFF1, out_rd echoed, out_valid exactly at T+3.
- MULW a = 0x1234_5678_7FFF_FFFF, b = 2 → out_data = 0xFFFF_FFFF_FFFF_FFFE. MULW a = 0x8000_0000, b = 2 → out_data = 0.
- Backpressure: out_ready = 0 for 5 cycles after out_valid → out_valid and out_data stable for all 5, in_ready = 0. Releasing out_ready gives exactly one handshake.
- Back-to-back: three MULs (2×3, 4×5, 6×7) with out_ready = 1 → results 6, 20, 42 in order, each MUL_LAT+2 cycles apart. mul_a does not change during BUSY (checked by model X-detection).
- flush during BUSY (cnt = 0) and during DONE with out_ready = 0 → no out_valid for the killed op; the next request (9×9) returns 81.
- reset asserted mid-BUSY for 1 cycle → all outputs 0 next cycle; in_ready = 1 the following cycle; a subsequent op completes correctly.
